// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer display path.
package reaction_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned LFSR_W     = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_TIMING = 3'd2,
        S_RESULT = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    // Index 0 is the thousandths digit, index 3 the seconds digit.
    typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] bcd_digits_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {^(cur & LFSR_TAPS), cur[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear that saturates at 9999.
module bcd_counter4
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output bcd_digits_t digits,
    output logic        max
);

    bcd_digits_t digits_nxt;
    logic        carry;
    logic        max_nxt;

    // Ripple the increment through the digits; a saturated count never moves.
    always_comb begin
        digits_nxt = digits;
        carry      = inc && !max;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (carry) begin
                if (digits[i] == BCD_W'(9)) begin
                    digits_nxt[i] = '0;
                end else begin
                    digits_nxt[i] = digits[i] + BCD_W'(1);
                    carry         = 1'b0;
                end
            end
        end
        if (clr) begin
            digits_nxt = '0;
        end
        max_nxt = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (digits_nxt[i] != BCD_W'(9)) begin
                max_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits <= '0;
            max    <= 1'b0;
        end else begin
            digits <= digits_nxt;
            max    <= max_nxt;
        end
    end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Sequences one reaction-time round: random wait, cue, BCD ms count, frozen result.
// Define EARLY_PRESS_DETECT_EN to send a stop press during the wait to the FAULT state.
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned DELAY_MIN_MS = 1000,
    parameter int unsigned DELAY_BITS   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_btn,
    input  logic             stop_btn,
    output logic [2:0]       state,
    output logic [BCD_W-1:0] ones,
    output logic [BCD_W-1:0] tenths,
    output logic [BCD_W-1:0] hundreths,
    output logic [BCD_W-1:0] thousandths,
    output logic             cue_led,
    output logic             timeout
);

    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DELAY_W = $clog2(DELAY_MIN_MS + (1 << DELAY_BITS));

    state_t              state_q;
    state_t              state_d;
    logic [LFSR_W-1:0]   lfsr;
    logic                start_q;
    logic                stop_q;
    logic                start_press;
    logic                stop_press;
    logic [TICK_W-1:0]   tick_cnt;
    logic                running;
    logic                tick;
    logic [DELAY_W-1:0]  delay_ms;
    logic                load_delay;
    logic                bcd_clr;
    logic                bcd_inc;
    logic                bcd_max;
    logic                timeout_set;
    bcd_digits_t         digits;

    assign start_press = start_btn && !start_q;
    assign stop_press  = stop_btn && !stop_q;
    assign running     = (state_q == S_WAIT) || (state_q == S_TIMING);
    assign tick        = running && (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop outranks start and tick in WAIT/TIMING; start only acts in IDLE/RESULT/FAULT.
    always_comb begin
        state_d     = state_q;
        load_delay  = 1'b0;
        bcd_inc     = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_press) begin
                    state_d    = S_WAIT;
                    load_delay = 1'b1;
                end
            end
            S_WAIT: begin
`ifdef EARLY_PRESS_DETECT_EN
                if (stop_press) begin
                    state_d = S_FAULT;
                end else
`endif
                if (tick && delay_ms == DELAY_W'(1)) begin
                    state_d = S_TIMING;
                end
            end
            S_TIMING: begin
                if (stop_press) begin
                    state_d = S_RESULT;
                end else if (tick) begin
                    if (bcd_max) begin
                        state_d     = S_RESULT;
                        timeout_set = 1'b1;
                    end else begin
                        bcd_inc = 1'b1;
                    end
                end
            end
            S_RESULT: begin
                if (start_press) begin
                    state_d    = S_WAIT;
                    load_delay = 1'b1;
                end
            end
`ifdef EARLY_PRESS_DETECT_EN
            S_FAULT: begin
                if (start_press) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // Only the RESULT state keeps the digits it was entered with.
        bcd_clr = (state_d != state_q) && (state_d != S_RESULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= LFSR_SEED;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            tick_cnt <= '0;
            delay_ms <= '0;
            cue_led  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            lfsr    <= lfsr_next(lfsr);
            start_q <= start_btn;
            stop_q  <= stop_btn;

            if (state_d != state_q || !running || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end

            if (load_delay) begin
                delay_ms <= DELAY_W'(DELAY_MIN_MS) + DELAY_W'(lfsr[DELAY_BITS-1:0]);
            end else if (state_q == S_WAIT && tick) begin
                delay_ms <= delay_ms - DELAY_W'(1);
            end

            cue_led <= (state_d == S_TIMING);

            if (timeout_set) begin
                timeout <= 1'b1;
            end else if (state_d != S_RESULT) begin
                timeout <= 1'b0;
            end
        end
    end

    bcd_counter4 u_count (
        .clk    (clk),
        .rst    (rst),
        .clr    (bcd_clr),
        .inc    (bcd_inc),
        .digits (digits),
        .max    (bcd_max)
    );

    assign state       = state_q;
    assign ones        = digits[3];
    assign tenths      = digits[2];
    assign hundreths   = digits[1];
    assign thousandths = digits[0];

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed self-checking bench for reaction_timer_ctrl (TICK_DIV=4, DELAY_MIN_MS=3, DELAY_BITS=2).
module tb_reaction_timer_ctrl;

    logic       clk;
    logic       rst;
    logic       start_btn;
    logic       stop_btn;
    logic [2:0] state;
    logic [3:0] ones;
    logic [3:0] tenths;
    logic [3:0] hundreths;
    logic [3:0] thousandths;
    logic       cue_led;
    logic       timeout;

    logic [15:0] digs;
    logic [15:0] lfsr_m;
    int          errors;
    int          checks;

    reaction_timer_ctrl #(
        .TICK_DIV     (4),
        .DELAY_MIN_MS (3),
        .DELAY_BITS   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_btn   (start_btn),
        .stop_btn    (stop_btn),
        .state       (state),
        .ones        (ones),
        .tenths      (tenths),
        .hundreths   (hundreths),
        .thousandths (thousandths),
        .cue_led     (cue_led),
        .timeout     (timeout)
    );

    assign digs = {ones, tenths, hundreths, thousandths};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent LFSR reference: x^16 + x^14 + x^13 + x^11, right-shifting
    always @(posedge clk) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // One-cycle button pulse; returns at the negedge after the edge that saw it.
    task automatic press(input logic s, input logic p);
        start_btn = s;
        stop_btn  = p;
        @(negedge clk);
        start_btn = 1'b0;
        stop_btn  = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max_cyc, input string name);
        int n;
        n = 0;
        while (state !== s && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (state !== s) begin
            errors++;
            $display("FAIL %s: state=%0d expected %0d within %0d cycles", name, state, s, max_cyc);
        end
    endtask

    task automatic go_timing(input string name);
        @(negedge clk);
        press(1'b1, 1'b0);
        wait_state(3'd2, 64, name);
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (state !== 3'd0)      begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (digs !== 16'h0000)   begin errors++; $display("FAIL reset_digits: got %h expected 0000", digs); end
        checks++; if (cue_led !== 1'b0)    begin errors++; $display("FAIL reset_cue: got %b expected 0", cue_led); end
        checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        rst = 1'b0;
    endtask

    task automatic test_wait_delay;
        int n;
        n = 0;
        while (lfsr_m[1:0] != 2'b01 && n < 64) begin
            @(negedge clk);
            n++;
        end
        press(1'b1, 1'b0);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL wait_entry: got %0d expected 1", state); end
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd1) begin errors++; $display("FAIL wait_held cycle %0d: got %0d expected 1", i, state); end
        end
        @(negedge clk);
        checks++; if (state !== 3'd2)     begin errors++; $display("FAIL wait_to_timing: got %0d expected 2", state); end
        checks++; if (cue_led !== 1'b1)   begin errors++; $display("FAIL cue_on: got %b expected 1", cue_led); end
        checks++; if (digs !== 16'h0000)  begin errors++; $display("FAIL timing_start_digits: got %h expected 0000", digs); end
    endtask

    task automatic test_stop_37;
        repeat (148) @(negedge clk);
        press(1'b0, 1'b1);
        checks++; if (state !== 3'd3)     begin errors++; $display("FAIL stop37_state: got %0d expected 3", state); end
        checks++; if (digs !== 16'h0037)  begin errors++; $display("FAIL stop37_digits: got %h expected 0037", digs); end
        checks++; if (cue_led !== 1'b0)   begin errors++; $display("FAIL stop37_cue: got %b expected 0", cue_led); end
        checks++; if (timeout !== 1'b0)   begin errors++; $display("FAIL stop37_timeout: got %b expected 0", timeout); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd3 || digs !== 16'h0037) begin
                errors++;
                $display("FAIL result_hold cycle %0d: got state %0d digits %h expected 3 0037", i, state, digs);
            end
        end
    endtask

    task automatic test_back_to_back;
        press(1'b1, 1'b0);
        checks++; if (state !== 3'd1)     begin errors++; $display("FAIL rearm_state: got %0d expected 1", state); end
        checks++; if (digs !== 16'h0000)  begin errors++; $display("FAIL rearm_digits: got %h expected 0000", digs); end
    endtask

    task automatic test_early_press;
        repeat (2) @(negedge clk);
        press(1'b0, 1'b1);
`ifdef EARLY_PRESS_DETECT_EN
        checks++; if (state !== 3'd4)     begin errors++; $display("FAIL early_fault: got %0d expected 4", state); end
        checks++; if (digs !== 16'h0000)  begin errors++; $display("FAIL fault_digits: got %h expected 0000", digs); end
        checks++; if (cue_led !== 1'b0)   begin errors++; $display("FAIL fault_cue: got %b expected 0", cue_led); end
        @(negedge clk);
        press(1'b1, 1'b0);
        checks++; if (state !== 3'd0)     begin errors++; $display("FAIL fault_exit: got %0d expected 0", state); end
`else
        checks++; if (state !== 3'd1)     begin errors++; $display("FAIL early_ignored: got %0d expected 1", state); end
        repeat (3) @(negedge clk);
        checks++; if (state !== 3'd1)     begin errors++; $display("FAIL early_still_wait: got %0d expected 1", state); end
        wait_state(3'd2, 64, "early_reach_timing");
        press(1'b0, 1'b1);
        checks++; if (state !== 3'd3)     begin errors++; $display("FAIL early_then_stop: got %0d expected 3", state); end
`endif
    endtask

    task automatic test_stop_tick_same_cycle;
        go_timing("same_cycle_reach_timing");
        repeat (167) @(negedge clk);
        press(1'b0, 1'b1);
        checks++; if (state !== 3'd3)     begin errors++; $display("FAIL same_cycle_state: got %0d expected 3", state); end
        checks++; if (digs !== 16'h0041)  begin errors++; $display("FAIL same_cycle_digits: got %h expected 0041", digs); end
    endtask

    task automatic test_both_buttons;
        press(1'b1, 1'b1);
        checks++; if (state !== 3'd1)     begin errors++; $display("FAIL both_in_result: got %0d expected 1", state); end
        wait_state(3'd2, 64, "both_reach_timing");
        repeat (6) @(negedge clk);
        press(1'b1, 1'b1);
        checks++; if (state !== 3'd3)     begin errors++; $display("FAIL both_in_timing: got %0d expected 3", state); end
        checks++; if (digs !== 16'h0001)  begin errors++; $display("FAIL both_digits: got %h expected 0001", digs); end
    endtask

    task automatic test_timeout;
        go_timing("timeout_reach_timing");
        repeat (39999) @(negedge clk);
        checks++; if (state !== 3'd2)     begin errors++; $display("FAIL pre_sat_state: got %0d expected 2", state); end
        checks++; if (digs !== 16'h9999)  begin errors++; $display("FAIL pre_sat_digits: got %h expected 9999", digs); end
        @(negedge clk);
        checks++; if (state !== 3'd3)     begin errors++; $display("FAIL sat_state: got %0d expected 3", state); end
        checks++; if (digs !== 16'h9999)  begin errors++; $display("FAIL sat_digits: got %h expected 9999", digs); end
        checks++; if (timeout !== 1'b1)   begin errors++; $display("FAIL sat_timeout: got %b expected 1", timeout); end
        checks++; if (cue_led !== 1'b0)   begin errors++; $display("FAIL sat_cue: got %b expected 0", cue_led); end
    endtask

    task automatic test_rst_mid_round;
        go_timing("rst_reach_timing");
        checks++; if (timeout !== 1'b0)   begin errors++; $display("FAIL rearm_timeout: got %b expected 0", timeout); end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd0)     begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", state); end
        checks++; if (digs !== 16'h0000)  begin errors++; $display("FAIL rst_mid_digits: got %h expected 0000", digs); end
        checks++; if (cue_led !== 1'b0)   begin errors++; $display("FAIL rst_mid_cue: got %b expected 0", cue_led); end
        rst = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_wait_delay();
        test_stop_37();
        test_back_to_back();
        test_early_press();
        test_stop_tick_same_cycle();
        test_both_buttons();
        test_timeout();
        test_rst_mid_round();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
